pipe_stage_elastic: RTL

Parametrised elastic pipeline-stage register: the next generation of the fixed IF/ID, ID/EX, EX/M and M/WB latches in the CPU pipeline. It carries an arbitrary-width payload under a valid/ready handshake. A two-entry skid buffer gives full throughput with backpressure and no combinational ready path. It adds synchronous flush to a configurable NOP payload, plus saturating stall and flush counters for pipeline profiling.

---
 rtl/pipe_stage_elastic_if.sv | 33 +++
 rtl/pipe_stage_elastic.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage.
// The upstream side (in_*) and downstream side (out_*) travel together so
// the instantiating stage wires a single bundle per pipeline boundary.
interface pipe_stage_elastic_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   // Seen from the stage itself.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   // Seen from the surrounding producer/consumer.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// The main entry drives the downstream side; the skid entry absorbs the one
// payload that can arrive after backpressure appears, so in_ready never
// depends combinationally on out_ready. A flush squashes both entries to the
// NOP payload. Two saturating counters profile stall and flush activity.
module pipe_stage_elastic #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}},
   parameter int               CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   flush,
   pipe_stage_elastic_if.slave    bus,
   output logic [1:0]             occupancy,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);

   // Encoding equals the number of held entries, so it doubles as occupancy.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q,     state_d;
   logic [WIDTH-1:0] main_q,      main_d;
   logic [WIDTH-1:0] skid_q,      skid_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;
   logic [CNT_W-1:0] stall_q,     stall_d;
   logic [CNT_W-1:0] flush_q,     flush_d;

   logic in_fire_s;
   logic out_fire_s;
   logic stall_inc_s;
   logic flush_inc_s;

   // Handshake qualifiers use only registered ready/valid plus the raw inputs.
   assign in_fire_s   = bus.in_valid & in_ready_q & ~flush;
   assign out_fire_s  = out_valid_q & bus.out_ready;
   assign stall_inc_s = out_valid_q & ~bus.out_ready;
   assign flush_inc_s = flush & (state_q != ST_EMPTY);

   // Next-state and entry-data selection; flush overrides the handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = NOP;
         skid_d  = NOP;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  main_d  = bus.in_data;
                  state_d = ST_ONE;
               end else begin
                  main_d  = NOP;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_d  = bus.in_data;
               end else if (in_fire_s) begin
                  skid_d  = bus.in_data;
                  state_d = ST_FULL;
               end else if (out_fire_s) begin
                  main_d  = NOP;
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire_s) begin
                  main_d  = skid_q;
                  skid_d  = NOP;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = NOP;
               skid_d  = NOP;
            end
         endcase
      end
   end

   // Registered handshake outputs are decoded from the upcoming state.
   always_comb begin
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   // Saturating profiling counters; flush never clears them.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_inc_s && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end else begin
         stall_d = stall_q;
      end
      if (flush_inc_s && (flush_q != CNT_MAX)) begin
         flush_d = flush_q + CNT_ONE;
      end else begin
         flush_d = flush_q;
      end
   end

   // State, entry and counter registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= ST_EMPTY;
         main_q      <= NOP;
         skid_q      <= NOP;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         stall_q     <= {CNT_W{1'b0}};
         flush_q     <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign occupancy     = state_q;
   assign stall_cnt     = stall_q;
   assign flush_cnt     = flush_q;

endmodule
